// File: rtl/fft8_if.sv
// Sample-in / bin-out streaming handshake for the 8-point FFT sequencer.
// master is the producer/consumer side, slave is the sequencer.
interface fft8_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_re;
  logic signed [7:0] in_im;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic signed [10:0] out_re;
  logic signed [10:0] out_im;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/fft8_sequencer.sv
// 8-point radix-2 DIT FFT sequencer: loads bit-reversed, issues 12
// butterflies to an external registered butterfly unit, streams bins.
module fft8_sequencer (
  input  logic        clk,
  input  logic        rst,
  fft8_if.slave       io,
  output logic        busy,
  output logic [1:0]  bf_k,
  output logic [21:0] bf_x0,
  output logic [21:0] bf_x1,
  input  logic [23:0] bf_a0,
  input  logic [23:0] bf_a1
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  s_q, s_d;
  logic [1:0]  b_q, b_d;
  logic [2:0]  i0_q, i0_d;
  logic [2:0]  i1_q, i1_d;
  logic [21:0] mem_q [8];

  logic [2:0] half, g, j, i0, i1, kk;
  logic [2:0] wr_addr;
  logic       accept;

  function automatic logic [10:0] sat11(input logic [11:0] v);
    if (v[11] != v[10])
      return v[11] ? 11'h400 : 11'h3ff;
    return v[10:0];
  endfunction

  // Butterfly addressing for stage s, butterfly b.
  always_comb begin
    half = 3'd1 << s_q;
    g    = {1'b0, b_q} >> s_q;
    j    = {1'b0, b_q} & (half - 3'd1);
    i0   = ((half << 1) * g) + j;
    i1   = i0 + half;
    kk   = j << (2'd2 - s_q);
  end

  assign wr_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};
  assign accept  = (state_q == LOAD) && io.in_valid;

  assign io.in_ready  = (state_q == LOAD);
  assign io.out_valid = (state_q == OUT);
  assign io.out_last  = (state_q == OUT) && (cnt_q == 3'd7);
  assign io.out_re    = (state_q == OUT) ? mem_q[cnt_q][21:11] : '0;
  assign io.out_im    = (state_q == OUT) ? mem_q[cnt_q][10:0]  : '0;

  assign busy  = (state_q == ISSUE) || (state_q == WB);
  assign bf_k  = (state_q == ISSUE) ? kk[1:0]   : '0;
  assign bf_x0 = (state_q == ISSUE) ? mem_q[i0] : '0;
  assign bf_x1 = (state_q == ISSUE) ? mem_q[i1] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    b_d     = b_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    unique case (state_q)
      LOAD: begin
        if (io.in_valid) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ISSUE;
            s_d     = 2'd0;
            b_d     = 2'd0;
          end
        end
      end
      ISSUE: begin
        i0_d    = i0;
        i1_d    = i1;
        state_d = WB;
      end
      WB: begin
        state_d = ISSUE;
        if (b_q != 2'd3) begin
          b_d = b_q + 2'd1;
        end else if (s_q != 2'd2) begin
          b_d = 2'd0;
          s_d = s_q + 2'd1;
        end else begin
          cnt_d   = 3'd0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (io.out_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      s_q     <= '0;
      b_q     <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      b_q     <= b_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
    end
  end

  // Working memory is never cleared; every entry is rewritten per frame.
  always_ff @(posedge clk) begin
    if (!rst && accept)
      mem_q[wr_addr] <= {{{3{io.in_re[7]}}, io.in_re},
                         {{3{io.in_im[7]}}, io.in_im}};
    if (!rst && state_q == WB) begin
      mem_q[i0_q] <= {sat11(bf_a0[23:12]), sat11(bf_a0[11:0])};
      mem_q[i1_q] <= {sat11(bf_a1[23:12]), sat11(bf_a1[11:0])};
    end
  end

endmodule

// File: tb/tb_fft8_sequencer.sv
// Directed bench for fft8_sequencer with a registered butterfly model.
module tb_fft8_sequencer;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [1:0]  bf_k;
  logic [21:0] bf_x0, bf_x1;
  logic [23:0] bf_a0, bf_a1;
  int          errors;
  int          checks;

  fft8_if io ();

  fft8_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .io    (io),
    .busy  (busy),
    .bf_k  (bf_k),
    .bf_x0 (bf_x0),
    .bf_x1 (bf_x1),
    .bf_a0 (bf_a0),
    .bf_a1 (bf_a1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x0 +/- W8^k * x1, twiddle scaled by 181/256 for the diagonal cases
  function automatic logic [23:0] bfly(input logic [21:0] x0,
                                       input logic [21:0] x1,
                                       input logic [1:0]  k,
                                       input bit          sub);
    int ar, ai, br, bi, tr, ti, rr, ri;
    ar = $signed(x0[21:11]);
    ai = $signed(x0[10:0]);
    br = $signed(x1[21:11]);
    bi = $signed(x1[10:0]);
    case (k)
      2'd0: begin tr = br; ti = bi; end
      2'd1: begin tr = (181 * (br + bi)) >>> 8; ti = (181 * (bi - br)) >>> 8; end
      2'd2: begin tr = bi; ti = -br; end
      default: begin tr = (181 * (bi - br)) >>> 8; ti = (181 * (-br - bi)) >>> 8; end
    endcase
    rr = sub ? ar - tr : ar + tr;
    ri = sub ? ai - ti : ai + ti;
    return {rr[11:0], ri[11:0]};
  endfunction

  always @(posedge clk) begin
    bf_a0 <= bfly(bf_x0, bf_x1, bf_k, 1'b0);
    bf_a1 <= bfly(bf_x0, bf_x1, bf_k, 1'b1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int re[8], input int im[8], input bit gaps);
    int w;
    for (int n = 0; n < 8; n++) begin
      if (gaps && (n % 2 == 1)) begin
        io.in_valid = 1'b0;
        tick();
      end
      io.in_valid = 1'b1;
      io.in_re    = 8'(re[n]);
      io.in_im    = 8'(im[n]);
      w = 0;
      while (!io.in_ready && w < 100) begin
        tick();
        w++;
      end
      if (w == 100) check("in_ready_timeout", 0, 1);
      tick();
    end
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit chk_lat, input bit junk);
    int lat;
    lat = 1;
    if (chk_lat) begin
      check("busy_compute", busy, 1);
      check("in_ready_compute", io.in_ready, 0);
      check("out_valid_compute", io.out_valid, 0);
    end
    io.in_valid = junk;
    io.in_re    = 8'sd55;
    io.in_im    = -8'sd33;
    while (!io.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    io.in_valid = 1'b0;
    check("out_valid_seen", io.out_valid, 1);
    if (chk_lat) check("latency", lat, 25);
    check("busy_out", busy, 0);
    check("bf_x0_out", int'(bf_x0), 0);
  endtask

  task automatic recv(input int er[8], input int ei[8], input bit bp);
    int w;
    for (int b = 0; b < 8; b++) begin
      w = 0;
      while (!io.out_valid && w < 100) begin
        tick();
        w++;
      end
      check($sformatf("bin%0d_re", b), io.out_re, er[b]);
      check($sformatf("bin%0d_im", b), io.out_im, ei[b]);
      check($sformatf("bin%0d_last", b), io.out_last, (b == 7) ? 1 : 0);
      if (bp && b == 3) begin
        io.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          tick();
          check("hold_valid", io.out_valid, 1);
          check("hold_re", io.out_re, er[b]);
          check("hold_im", io.out_im, ei[b]);
        end
      end
      io.out_ready = 1'b1;
      tick();
      io.out_ready = 1'b0;
    end
    check("back_to_load_ready", io.in_ready, 1);
    check("back_to_load_valid", io.out_valid, 0);
  endtask

  initial begin
    int zr[8], xr[8], xi[8], er[8], ei[8];
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_re     = '0;
    io.in_im     = '0;
    io.out_ready = 1'b0;
    zr = '{0, 0, 0, 0, 0, 0, 0, 0};
    tick();
    tick();
    check("rst_in_ready", io.in_ready, 1);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bf_x1", int'(bf_x1), 0);
    rst = 1'b0;
    tick();
    check("bf_k_load", bf_k, 0);

    // impulse, with latency check
    xr = '{100, 0, 0, 0, 0, 0, 0, 0};
    er = '{100, 100, 100, 100, 100, 100, 100, 100};
    send(xr, zr, 1'b0);
    wait_out(1'b1, 1'b0);
    recv(er, zr, 1'b0);

    // DC with input gaps
    xr = '{10, 10, 10, 10, 10, 10, 10, 10};
    er = '{80, 0, 0, 0, 0, 0, 0, 0};
    send(xr, zr, 1'b1);
    wait_out(1'b1, 1'b0);
    recv(er, zr, 1'b0);

    // alternating, with junk in_valid while computing
    xr = '{10, -10, 10, -10, 10, -10, 10, -10};
    er = '{0, 0, 0, 0, 80, 0, 0, 0};
    send(xr, zr, 1'b0);
    wait_out(1'b0, 1'b1);
    recv(er, zr, 1'b0);

    // shifted impulse x[2]=100 -> bins 100*(-j)^k, with backpressure
    xr = '{0, 0, 100, 0, 0, 0, 0, 0};
    er = '{100, 0, -100, 0, 100, 0, -100, 0};
    ei = '{0, -100, 0, 100, 0, -100, 0, 100};
    send(xr, zr, 1'b0);
    wait_out(1'b0, 1'b0);
    recv(er, ei, 1'b1);

    // full scale negative
    xr = '{-128, -128, -128, -128, -128, -128, -128, -128};
    er = '{-1024, 0, 0, 0, 0, 0, 0, 0};
    send(xr, xr, 1'b0);
    wait_out(1'b0, 1'b0);
    recv(er, er, 1'b0);

    // full scale positive
    xr = '{127, 127, 127, 127, 127, 127, 127, 127};
    er = '{1016, 0, 0, 0, 0, 0, 0, 0};
    send(xr, zr, 1'b0);
    wait_out(1'b0, 1'b0);
    recv(er, zr, 1'b0);

    // reset at cycle 10 of compute, then a fresh DC frame
    xr = '{77, -5, 3, 9, -60, 12, 1, 40};
    send(xr, xr, 1'b0);
    repeat (9) tick();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_ready", io.in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", io.out_valid, 0);
    xr = '{10, 10, 10, 10, 10, 10, 10, 10};
    er = '{80, 0, 0, 0, 0, 0, 0, 0};
    send(xr, zr, 1'b0);
    wait_out(1'b1, 1'b0);
    recv(er, zr, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
